aurora_20g_pattern_gen: RTL and testbench
=========================================

Name: aurora_20g_pattern_gen

Overview:
Transmit-side test-pattern source for the 20G Aurora user link. Drives a 128-bit AXI-stream with:
- control flags (clear, ADC start, packet end);
- header beats carrying a 64-bit incrementing encoder sequence;
- ADC beats carrying a lane-incrementing 16-bit pattern.
It sits in front of the Aurora TX user interface. A far-end receive checker that parses headers and ADC beats counts the stream as all-success unless an error is injected.

Parameters:
- DATA_WD, 128, stream data width (fixed 128; eight 16-bit lanes)
- HEAD_WD, 64, width of encoder sequence in header beat
- PKT_BEATS, 64, ADC beats per packet (>=1)
- GAP_CYC, 0, idle cycles (tvalid=0) between packets

Ports:
- clk  in  1  single clock; all logic synchronous to it
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  pulse: begin a run (ignored while busy)
- cfg_stop  in  1  pulse: end the run after the current packet
- cfg_clr  in  1  pulse: send PKT_CLR flag
- cfg_err_inj  in  1  pulse: corrupt the next ADC beat
- cfg_pkt_num  in  32  packets per run; 0 = unlimited; sampled at start
- m_axis_tdata  out  128  stream data
- m_axis_tkeep  out  16  byte enables, always 16'hFFFF
- m_axis_tvalid  out  1  stream valid
- m_axis_tlast  out  1  end of packet / single-beat flag
- m_axis_tready  in  1  downstream ready
- busy  out  1  run in progress (state != IDLE)
- tx_pkt_cnt  out  32  completed packets since rst/cfg_clr, wraps
- tx_beat_cnt  out  32  accepted beats (tvalid&&tready), wraps

Behaviour:
- Flag constants:
  - PKT_CLR = AABBCCDD_AA55FF00_55AA0001_00000001
  - ADC_START = AABBCCDD_AA55FF00_55AA0001_00000002
  - PKT_END = 5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF
  - Each flag is sent as a single beat with tlast=1.
- Reset: state IDLE; tvalid, tlast, busy = 0; tdata = 0; all counters and sequences = 0; pending flags cleared.
- Outputs are registered. A beat is "accepted" when tvalid&&tready. While tvalid=1 and tready=0, tdata/tlast are held stable.
- Next beat is loaded in the accept cycle, so back-to-back throughput is 1 beat/clk.
- FSM states: IDLE, CLR, START, HEAD, ADC, GAP, END.
  - IDLE: on cfg_clr -> CLR; else on cfg_start -> START (latch cfg_pkt_num; enc_seq=0, adc_seq=0).
  - CLR: present PKT_CLR. On accept: if a run is active -> HEAD; else -> IDLE. Also zeroes tx_pkt_cnt and tx_beat_cnt; tx_beat_cnt restarts counting from the accepted flag beat.
  - START: present ADC_START; on accept -> HEAD.
  - HEAD: tdata = {enc_seq[63:0], 64'h0}, tlast=0; on accept -> ADC.
  - ADC: lane i (tdata[16i+15:16i], i=0..7) = adc_seq+i mod 2^16. adc_seq += 8 per accepted beat, wrapping. tlast=1 on beat PKT_BEATS-1.
  - On the last accept of a packet: tx_pkt_cnt++, enc_seq++. Next state:
    - END if stop is pending or the packet count has reached a nonzero cfg_pkt_num;
    - otherwise CLR if clr is pending;
    - otherwise GAP if GAP_CYC>0;
    - otherwise HEAD.
  - GAP: tvalid=0 for GAP_CYC cycles, then HEAD.
  - END: present PKT_END; on accept -> IDLE.
- Pending flags: cfg_stop and cfg_clr arriving outside IDLE are latched and consumed at the next packet boundary; they never split a packet.
  - If cfg_stop and cfg_clr are both pending, END is sent first and CLR follows from IDLE.
  - If cfg_clr and cfg_start arrive in the same cycle in IDLE, CLR is sent first and START is held pending.
  - cfg_start while busy is ignored.
- Error inject: the next ADC beat presented has tdata[0] inverted. adc_seq progression is unchanged, so exactly one beat is corrupt. A second pulse before consumption merges with the first.
- cfg_pkt_num=1 gives START, HEAD, ADC x PKT_BEATS, END.
- rst mid-packet: immediate return to IDLE with tvalid=0. An AXI truncation is permitted only under reset.

Decomposition:
- Shared package aurora_20g_pkg holds:
  - PKT_CLR_FLAG, ADC_START_FLAG, PKT_END_FLAG;
  - the lane count (8) and lane width (16);
  - the FSM state enum.
  The receive checker imports the same package.
- One natural sub-module: aurora_20g_adc_pat, which holds adc_seq and generates the 8-lane beat combinationally, with advance and restart inputs.
- Counters reuse the existing 32-bit app counter.

Test Plan:
- Basic run: PKT_BEATS=4, cfg_pkt_num=2, tready=1 -> 12 beats total:
  - ADC_START, then HEAD {0,0}, then ADC beats lanes 0..7 / 8..15 / 16..23 / 24..31 with tlast on the 4th;
  - HEAD {1,0}, then ADC 32..63;
  - PKT_END.
  Ends with tx_pkt_cnt=2, tx_beat_cnt=12, busy=0.
- Backpressure: random tready at 30% -> tdata/tlast are never changed while tvalid&&!tready, and the beat sequence is identical to the tready=1 run.
- Stop mid-packet: cfg_pkt_num=0, cfg_stop pulsed at ADC beat 1 of packet 3 -> packet 3 completes with its tlast, then PKT_END, then IDLE; tx_pkt_cnt=3.
- Clear during a run: cfg_clr pulsed mid-packet -> PKT_CLR appears right after that packet's tlast beat, then HEAD with the enc_seq continuing; tx_pkt_cnt reads 0 after the flag is accepted.
- Error inject: pulse during packet 0 -> exactly one ADC beat has bit0 flipped (e.g. lane0 0x0001 instead of 0x0000), and the following beat is correct (lane0 = 0x0008).
- Reset mid-packet: rst asserted at ADC beat 2 -> next cycle tvalid=0, busy=0, counters=0; a subsequent cfg_start restarts with enc_seq=0 and adc_seq=0.

Source files
------------

// File: rtl/aurora_20g_pkg.sv
// Shared definitions for the 20G Aurora test-pattern source and its
// far-end receive checker: flag beats, ADC lane geometry, FSM states.
package aurora_20g_pkg;

  localparam int LANES   = 8;
  localparam int LANE_WD = 16;

  localparam logic [127:0] PKT_CLR_FLAG =
    128'hAABBCCDD_AA55FF00_55AA0001_00000001;
  localparam logic [127:0] ADC_START_FLAG =
    128'hAABBCCDD_AA55FF00_55AA0001_00000002;
  localparam logic [127:0] PKT_END_FLAG =
    128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_START,
    ST_HEAD,
    ST_ADC,
    ST_GAP,
    ST_END
  } state_e;

endpackage

// File: rtl/aurora_20g_adc_pat.sv
// ADC lane pattern: holds adc_seq, presents the beat for the
// sequence value that will be current after this clock.
module aurora_20g_adc_pat
  import aurora_20g_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  input  logic                     restart,
  output logic [LANES*LANE_WD-1:0] beat
);

  logic [LANE_WD-1:0] seq;
  logic [LANE_WD-1:0] seq_nxt;

  always_comb begin
    seq_nxt = seq;
    if (restart)
      seq_nxt = '0;
    else if (advance)
      seq_nxt = seq + LANE_WD'(LANES);
  end

  always_ff @(posedge clk) begin
    if (rst)
      seq <= '0;
    else
      seq <= seq_nxt;
  end

  always_comb begin
    beat = '0;
    for (int i = 0; i < LANES; i++)
      beat[i*LANE_WD +: LANE_WD] = seq_nxt + LANE_WD'(i);
  end

endmodule

// File: rtl/aurora_20g_pattern_gen.sv
// TX test-pattern source for the 20G Aurora user link: flag beats,
// header beats with encoder sequence and lane-incrementing ADC beats.
module aurora_20g_pattern_gen
  import aurora_20g_pkg::*;
#(
  parameter int DATA_WD   = 128,
  parameter int HEAD_WD   = 64,
  parameter int PKT_BEATS = 64,
  parameter int GAP_CYC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic               cfg_clr,
  input  logic               cfg_err_inj,
  input  logic [31:0]        cfg_pkt_num,
  output logic [DATA_WD-1:0] m_axis_tdata,
  output logic [15:0]        m_axis_tkeep,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic [31:0]        tx_pkt_cnt,
  output logic [31:0]        tx_beat_cnt
);

  localparam int IW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PKT_BEATS - 1);

  state_e             state, nxt;
  logic               acc, pkt_done, last_beat, ld, start_go;
  logic               stop_hit, clr_hit, err_hit, end_hit;
  logic               run_active;
  logic               stop_pend, clr_pend, start_pend, err_pend;
  logic [IW-1:0]      idx, idx_nxt;
  logic [HEAD_WD-1:0] enc_seq, enc_nxt;
  logic [31:0]        pkt_num, run_pkts, gap_cnt;
  logic [DATA_WD-1:0] pat_beat;

  assign acc       = m_axis_tvalid & m_axis_tready;
  assign last_beat = idx == LAST_IDX;
  assign pkt_done  = (state == ST_ADC) && acc && last_beat;
  assign stop_hit  = stop_pend | cfg_stop;
  assign clr_hit   = clr_pend | cfg_clr;
  assign err_hit   = err_pend | cfg_err_inj;
  assign end_hit   = stop_hit ||
    (pkt_num != 0 && run_pkts + 1'b1 == pkt_num);
  assign enc_nxt   = pkt_done ? enc_seq + 1'b1 : enc_seq;
  assign idx_nxt   = (state == ST_ADC && acc) ?
    (last_beat ? '0 : idx + 1'b1) : idx;

  assign busy         = state != ST_IDLE;
  assign m_axis_tkeep = '1;

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:
        if (clr_hit)
          nxt = ST_CLR;
        else if (cfg_start | start_pend)
          nxt = ST_START;
      ST_CLR:
        if (acc) nxt = run_active ? ST_HEAD : ST_IDLE;
      ST_START:
        if (acc) nxt = ST_HEAD;
      ST_HEAD:
        if (acc) nxt = ST_ADC;
      ST_ADC:
        if (pkt_done) begin
          if (end_hit)
            nxt = ST_END;
          else if (clr_hit)
            nxt = ST_CLR;
          else if (GAP_CYC > 0)
            nxt = ST_GAP;
          else
            nxt = ST_HEAD;
        end
      ST_GAP:
        if (gap_cnt == 32'(GAP_CYC - 1)) nxt = ST_HEAD;
      ST_END:
        if (acc) nxt = ST_IDLE;
      default:
        nxt = ST_IDLE;
    endcase
  end

  // Output registers reload whenever the presented beat is consumed
  // or the state changes, so a stalled beat never moves.
  assign ld       = (nxt != state) || (state == ST_ADC && acc);
  assign start_go = (state == ST_IDLE) && (nxt == ST_START);

  aurora_20g_adc_pat u_pat (
    .clk     (clk),
    .rst     (rst),
    .advance (state == ST_ADC && acc),
    .restart (start_go),
    .beat    (pat_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      run_active    <= 1'b0;
      stop_pend     <= 1'b0;
      clr_pend      <= 1'b0;
      start_pend    <= 1'b0;
      err_pend      <= 1'b0;
      idx           <= '0;
      enc_seq       <= '0;
      pkt_num       <= '0;
      run_pkts      <= '0;
      gap_cnt       <= '0;
      tx_pkt_cnt    <= '0;
      tx_beat_cnt   <= '0;
    end else begin
      state <= nxt;
      if (ld) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b1;
        unique case (nxt)
          ST_CLR:   m_axis_tdata <= PKT_CLR_FLAG;
          ST_START: m_axis_tdata <= ADC_START_FLAG;
          ST_END:   m_axis_tdata <= PKT_END_FLAG;
          ST_HEAD: begin
            m_axis_tdata <=
              {enc_nxt, {(DATA_WD-HEAD_WD){1'b0}}};
            m_axis_tlast <= 1'b0;
          end
          ST_ADC: begin
            m_axis_tdata <= pat_beat ^ DATA_WD'(err_hit);
            m_axis_tlast <= idx_nxt == LAST_IDX;
          end
          default: begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
        endcase
      end

      enc_seq  <= start_go ? '0 : enc_nxt;
      idx      <= start_go ? '0 : idx_nxt;
      gap_cnt  <= (state == ST_GAP && nxt == ST_GAP) ?
        gap_cnt + 1'b1 : '0;

      if (start_go) begin
        pkt_num    <= cfg_pkt_num;
        run_pkts   <= '0;
        run_active <= 1'b1;
      end else if (pkt_done) begin
        run_pkts <= run_pkts + 1'b1;
      end
      if (state == ST_END && acc)
        run_active <= 1'b0;

      // Pending requests wait for a packet boundary.
      if (state == ST_IDLE)
        start_pend <= (nxt == ST_CLR) & (cfg_start | start_pend);
      clr_pend  <= (nxt == ST_CLR && state != ST_CLR) ? 1'b0 :
        (state != ST_IDLE) & clr_hit;
      stop_pend <= (nxt == ST_END) ? 1'b0 :
        run_active & (state != ST_IDLE) &
        (state != ST_END) & stop_hit;
      err_pend  <= (ld && nxt == ST_ADC) ? 1'b0 : err_hit;

      if (state == ST_CLR && acc)
        tx_beat_cnt <= 32'd1;
      else if (acc)
        tx_beat_cnt <= tx_beat_cnt + 1'b1;

      if (state == ST_CLR && acc)
        tx_pkt_cnt <= '0;
      else if (pkt_done)
        tx_pkt_cnt <= tx_pkt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aurora_20g_pattern_gen.sv
// Scoreboard bench for aurora_20g_pattern_gen with 4-beat packets:
// directed runs, backpressure, stop, clear, error inject, reset.
module tb_aurora_20g_pattern_gen;

  localparam logic [127:0] F_CLR =
    128'hAABBCCDD_AA55FF00_55AA0001_00000001;
  localparam logic [127:0] F_START =
    128'hAABBCCDD_AA55FF00_55AA0001_00000002;
  localparam logic [127:0] F_END =
    128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

  typedef struct {
    logic [127:0] d;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start, cfg_stop, cfg_clr, cfg_err_inj;
  logic [31:0]  cfg_pkt_num;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tvalid, tlast;
  logic         tready = 1'b1;
  logic         busy;
  logic [31:0]  pkt_cnt, beat_cnt;

  int    n_vec = 0;
  int    n_bad = 0;
  bit    bp_en = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  aurora_20g_pattern_gen #(
    .DATA_WD   (128),
    .HEAD_WD   (64),
    .PKT_BEATS (4),
    .GAP_CYC   (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_clr       (cfg_clr),
    .cfg_err_inj   (cfg_err_inj),
    .cfg_pkt_num   (cfg_pkt_num),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .busy          (busy),
    .tx_pkt_cnt    (pkt_cnt),
    .tx_beat_cnt   (beat_cnt)
  );

  task automatic check(string tag, logic [127:0] obs,
                       logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] adc_beat(logic [15:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[i*16 +: 16] = s + 16'(i);
    return r;
  endfunction

  task automatic push(logic [127:0] d, logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(logic [63:0] enc, logic [15:0] s0,
                          bit err);
    logic [127:0] d;
    push({enc, 64'h0}, 1'b0);
    for (int b = 0; b < 4; b++) begin
      d = adc_beat(s0 + 16'(8 * b));
      if (b == 0 && err) d[0] = ~d[0];
      push(d, b == 3);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run(logic [31:0] n);
    cfg_pkt_num = n;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int k = 0;
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    check({tag, "_idle_timeout"}, 128'(busy), 128'(0));
  endtask

  task automatic wait_beats(string tag, logic [31:0] n);
    int k = 0;
    while (beat_cnt != n && k < 2000) begin
      tick();
      k++;
    end
    check({tag, "_beat_wait"}, 128'(beat_cnt), 128'(n));
  endtask

  always @(posedge clk) begin
    #1;
    tready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Scoreboard pop on accept, plus hold check while stalled.
  logic         held_v = 1'b0;
  logic [127:0] held_d;
  logic         held_l;
  beat_t        got;

  always @(negedge clk) begin
    if (held_v && !rst) begin
      check("stall_valid", 128'(tvalid), 128'(1));
      check("stall_data", tdata, held_d);
      check("stall_last", 128'(tlast), 128'(held_l));
    end
    held_v = tvalid && !tready && !rst;
    held_d = tdata;
    held_l = tlast;
    if (!rst && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $error("FAIL unexpected_beat observed=%h expected=none",
               tdata);
      end else begin
        got = exp_q.pop_front();
        check("beat_data", tdata, got.d);
        check("beat_last", 128'(tlast), 128'(got.l));
      end
    end
  end

  initial begin
    rst = 1'b1;
    cfg_start = 0;
    cfg_stop = 0;
    cfg_clr = 0;
    cfg_err_inj = 0;
    cfg_pkt_num = 0;
    tick();
    tick();
    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_tlast", 128'(tlast), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_tdata", tdata, 128'(0));
    check("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    check("rst_beat_cnt", 128'(beat_cnt), 128'(0));
    check("tkeep", 128'(tkeep), 128'h0000_FFFF);
    rst = 1'b0;
    tick();

    // basic two-packet run
    push(F_START, 1'b1);
    push_pkt(64'd0, 16'd0, 0);
    push_pkt(64'd1, 16'd32, 0);
    push(F_END, 1'b1);
    start_run(32'd2);
    wait_done("basic");
    check("basic_q", 128'(exp_q.size()), 128'(0));
    check("basic_pkt_cnt", 128'(pkt_cnt), 128'(2));
    check("basic_beat_cnt", 128'(beat_cnt), 128'(12));
    check("basic_tvalid", 128'(tvalid), 128'(0));

    // same run under random backpressure
    bp_en = 1;
    push(F_START, 1'b1);
    push_pkt(64'd0, 16'd0, 0);
    push_pkt(64'd1, 16'd32, 0);
    push(F_END, 1'b1);
    start_run(32'd2);
    wait_done("bp");
    bp_en = 0;
    tick();
    check("bp_q", 128'(exp_q.size()), 128'(0));
    check("bp_pkt_cnt", 128'(pkt_cnt), 128'(4));
    check("bp_beat_cnt", 128'(beat_cnt), 128'(24));

    // stop during ADC beat 1 of the third packet
    pulse_rst();
    push(F_START, 1'b1);
    push_pkt(64'd0, 16'd0, 0);
    push_pkt(64'd1, 16'd32, 0);
    push_pkt(64'd2, 16'd64, 0);
    push(F_END, 1'b1);
    start_run(32'd0);
    wait_beats("stop", 32'd13);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_done("stop");
    check("stop_q", 128'(exp_q.size()), 128'(0));
    check("stop_pkt_cnt", 128'(pkt_cnt), 128'(3));
    check("stop_beat_cnt", 128'(beat_cnt), 128'(17));

    // clear mid-packet in a three-packet run
    pulse_rst();
    push(F_START, 1'b1);
    push_pkt(64'd0, 16'd0, 0);
    push(F_CLR, 1'b1);
    push_pkt(64'd1, 16'd32, 0);
    push_pkt(64'd2, 16'd64, 0);
    push(F_END, 1'b1);
    start_run(32'd3);
    wait_beats("clr_a", 32'd3);
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
    wait_beats("clr_b", 32'd1);
    check("clr_pkt_zero", 128'(pkt_cnt), 128'(0));
    wait_done("clr");
    check("clr_q", 128'(exp_q.size()), 128'(0));
    check("clr_pkt_cnt", 128'(pkt_cnt), 128'(2));
    check("clr_beat_cnt", 128'(beat_cnt), 128'(12));

    // error inject on the first ADC beat only
    pulse_rst();
    push(F_START, 1'b1);
    push_pkt(64'd0, 16'd0, 1);
    push(F_END, 1'b1);
    start_run(32'd1);
    cfg_err_inj = 1'b1;
    tick();
    cfg_err_inj = 1'b0;
    wait_done("err");
    check("err_q", 128'(exp_q.size()), 128'(0));
    check("err_pkt_cnt", 128'(pkt_cnt), 128'(1));

    // reset while ADC beat 2 is presented
    pulse_rst();
    push(F_START, 1'b1);
    push({64'd0, 64'h0}, 1'b0);
    push(adc_beat(16'd0), 1'b0);
    push(adc_beat(16'd8), 1'b0);
    start_run(32'd0);
    wait_beats("mrst", 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_tvalid", 128'(tvalid), 128'(0));
    check("mrst_busy", 128'(busy), 128'(0));
    check("mrst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    check("mrst_beat_cnt", 128'(beat_cnt), 128'(0));
    check("mrst_q", 128'(exp_q.size()), 128'(0));
    push(F_START, 1'b1);
    push_pkt(64'd0, 16'd0, 0);
    push(F_END, 1'b1);
    start_run(32'd1);
    wait_done("mrst_run");
    check("mrst_run_q", 128'(exp_q.size()), 128'(0));
    check("mrst_run_beats", 128'(beat_cnt), 128'(7));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
